uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares one 8-N-1 UART transmitter among `NUM_REQ` byte producers. It accepts one byte at a time from the winning requester and pulses the transmitter's `start` with that byte on `data`. It then tracks the transmitter's `busy` until the frame completes, and only then accepts the next byte. It sits between the application sources and the transmitter.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2..8.
- `BUSY_TIMEOUT`, default 4: cycles allowed for `tx_busy` to rise after a launch; legal range 2..255.
- `clk`  in  1  system clock; all state is updated on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  `NUM_REQ`  requester i has a byte pending; held until acknowledged.
- `req_data`  in  `8*NUM_REQ`  byte of requester i at `[8*i+7:8*i]`; held while valid.
- `req_ready`  out  `NUM_REQ`  one-cycle acknowledge pulse: byte of requester i consumed.
- `tx_start`  out  1  one-cycle launch pulse to the transmitter.
- `tx_data`  out  8  byte to the transmitter; stable from launch until the next launch.
- `tx_busy`  in  1  transmitter busy flag.
- `grant_id`  out  3  index of the requester currently being served.
- `active`  out  1  high from capture until frame completion.
- `err_timeout`  out  1  sticky: a launch was not acknowledged by `tx_busy`.

## Operation
- All outputs are registered. Reset values: `req_ready`=0, `tx_start`=0, `tx_data`=0, `grant_id`=0, `active`=0, `err_timeout`=0.
- Internal `last_grant` resets to `NUM_REQ-1`, so requester 0 has first priority after reset.
- State machine:
  - **S_IDLE**
    - Search for a set `req_valid` starting at `last_grant+1`, wrapping modulo `NUM_REQ`; the first set bit wins as g.
    - On the capture edge: latch `req_data[g]` into the hold register, `grant_id<=g`, `active<=1`, `req_ready[g]<=1`, `tx_start<=1`, `tx_data<=byte`.
    - Then go to S_WAIT_BUSY.
    - With no valid request, all outputs hold and `active`=0.
  - **S_WAIT_BUSY**
    - Clear `tx_start` and `req_ready`; count cycles.
    - If `tx_busy`=1, go to S_WAIT_DONE.
    - If the count reaches `BUSY_TIMEOUT` with no busy: `err_timeout<=1`, drop the byte, `last_grant<=grant_id`, `active<=0`, go to S_IDLE.
  - **S_WAIT_DONE**
    - When `tx_busy`=0: `last_grant<=grant_id`, `active<=0`, go to S_IDLE.
    - Tag build only: go to S_LAUNCH if the data byte is still pending (see Configuration).
  - **S_LAUNCH** (tag build only)
    - `tx_start<=1`, `tx_data<=hold`, go to S_WAIT_BUSY.
- Requesters must keep valid and data stable until they see `req_ready`. They drop or advance valid on the edge that ends the ready cycle.
- S_IDLE is re-entered only after completion, so a still-high valid is never double-captured.
- Valid requests that are not granted are unaffected. Deasserting valid before ready is illegal; behaviour is undefined.
- Timeout counter: 8 bits, cleared on every launch.

## Timing
- Capture latency: valid seen in S_IDLE at edge k; `req_ready` and `tx_start` are high in cycle k..k+1.
- `tx_busy` is expected visible from edge k+1. The first S_WAIT_BUSY cycle seeing busy=0 is normal.
- Completion: the edge after `tx_busy` falls returns to S_IDLE. The next capture can occur one edge later, giving 2 idle cycles between frames at most.
- Back-to-back throughput: one byte per transmitter frame plus 3 cycles.
- Simultaneous valids: served strictly in rotating order. A requester that was just served is not served again while another requester is valid.
- Reset asserted mid-frame: all outputs return to reset values immediately, `last_grant` returns to `NUM_REQ-1`, and the byte in flight is abandoned. No `req_ready` is reissued for it.

## Configuration
- `UART_ARB_TAG_EN` defined:
  - Each capture first launches the tag byte `8'hA0 | grant_id`.
  - After that frame's busy falls, S_LAUNCH sends the held data byte.
  - `req_ready` is still pulsed at capture.
  - `active` spans both frames; `last_grant` updates after the data frame.
  - A timeout on the tag frame drops both bytes.
- Undefined: S_LAUNCH and its logic are absent, and only the data byte is sent.

## Test plan
- Reset, then `req_valid`=4'b0001 with byte 0x55 → `req_ready[0]` pulses once, `tx_start` pulses once with `tx_data`=0x55, and `active` falls the edge after busy falls.
- All four valid with bytes 0x10/0x21/0x32/0x43, held until acked → frames are transmitted in order 0x10, 0x21, 0x32, 0x43, with exactly one ready per requester.
- Requester 2 served, then requesters 2 and 3 both valid → 3 is served before 2.
- `rst_n` pulsed low in the middle of the data bits → `tx_start`, `active`, `req_ready` and `grant_id` read 0 at once. After release, requester 0 wins over a simultaneous requester 3.
- `tx_busy` tied 0, single request → `err_timeout` rises `BUSY_TIMEOUT` cycles after launch, the FSM returns to S_IDLE, and the next request is still served.
- `UART_ARB_TAG_EN` build, requester 1 sends 0x7E → two frames, 0xA1 then 0x7E; `active` is high across both.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8-N-1 UART transmitter; UART_ARB_TAG_EN prefixes each byte with tag 8'hA0|grant_id.
// Capture 1 cycle after valid is seen in idle; no new capture until the frame's busy falls (or the launch times out).
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic [2:0]           grant_id,
    output logic                 active,
    output logic                 err_timeout
);

    localparam int IDXW = $clog2(NUM_REQ);

`ifdef UART_ARB_TAG_EN
    typedef enum logic [1:0] {S_IDLE, S_WAIT_BUSY, S_WAIT_DONE, S_LAUNCH} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_WAIT_BUSY, S_WAIT_DONE} state_t;
`endif

    state_t             state, state_nxt;
    logic [2:0]         last_grant, last_nxt;
    logic [7:0]         tmo_cnt, cnt_nxt;
    logic [NUM_REQ-1:0] ready_nxt;
    logic               start_nxt;
    logic [7:0]         data_nxt;
    logic [2:0]         grant_nxt;
    logic               active_nxt;
    logic               err_nxt;
`ifdef UART_ARB_TAG_EN
    logic [7:0]         hold, hold_nxt;
    logic               data_pend, pend_nxt;
`endif

    logic               found;
    logic [2:0]         win;
    logic [NUM_REQ-1:0] win_onehot;
    logic [7:0]         sel_byte;
    int                 idx;

    // Rotating search: the requester after the last one served has top priority.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(last_grant) + i) % NUM_REQ;
            if (!found && req_valid[IDXW'(idx)]) begin
                found = 1'b1;
                win   = 3'(idx);
            end
        end
    end

    always_comb begin
        win_onehot = '0;
        sel_byte   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == 3'(i)) begin
                win_onehot[i] = 1'b1;
                sel_byte      = req_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        last_nxt   = last_grant;
        cnt_nxt    = tmo_cnt;
        ready_nxt  = '0;
        start_nxt  = 1'b0;
        data_nxt   = tx_data;
        grant_nxt  = grant_id;
        active_nxt = active;
        err_nxt    = err_timeout;
`ifdef UART_ARB_TAG_EN
        hold_nxt   = hold;
        pend_nxt   = data_pend;
`endif
        case (state)
            S_IDLE: begin
                if (found) begin
                    ready_nxt  = win_onehot;
                    start_nxt  = 1'b1;
                    grant_nxt  = win;
                    active_nxt = 1'b1;
                    cnt_nxt    = '0;
`ifdef UART_ARB_TAG_EN
                    data_nxt   = 8'hA0 | {5'b0, win};
                    hold_nxt   = sel_byte;
                    pend_nxt   = 1'b1;
`else
                    data_nxt   = sel_byte;
`endif
                    state_nxt  = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_nxt = S_WAIT_DONE;
                end else if (tmo_cnt == 8'(BUSY_TIMEOUT - 1)) begin
                    // Transmitter never acknowledged: drop whatever is left of this grant.
                    err_nxt    = 1'b1;
                    last_nxt   = grant_id;
                    active_nxt = 1'b0;
                    state_nxt  = S_IDLE;
`ifdef UART_ARB_TAG_EN
                    pend_nxt   = 1'b0;
`endif
                end else begin
                    cnt_nxt = tmo_cnt + 8'd1;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
`ifdef UART_ARB_TAG_EN
                    if (data_pend) begin
                        pend_nxt  = 1'b0;
                        state_nxt = S_LAUNCH;
                    end else begin
                        last_nxt   = grant_id;
                        active_nxt = 1'b0;
                        state_nxt  = S_IDLE;
                    end
`else
                    last_nxt   = grant_id;
                    active_nxt = 1'b0;
                    state_nxt  = S_IDLE;
`endif
                end
            end
`ifdef UART_ARB_TAG_EN
            S_LAUNCH: begin
                start_nxt = 1'b1;
                data_nxt  = hold;
                cnt_nxt   = '0;
                state_nxt = S_WAIT_BUSY;
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            last_grant  <= 3'(NUM_REQ - 1);
            tmo_cnt     <= '0;
            req_ready   <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            grant_id    <= '0;
            active      <= 1'b0;
            err_timeout <= 1'b0;
`ifdef UART_ARB_TAG_EN
            hold        <= '0;
            data_pend   <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            last_grant  <= last_nxt;
            tmo_cnt     <= cnt_nxt;
            req_ready   <= ready_nxt;
            tx_start    <= start_nxt;
            tx_data     <= data_nxt;
            grant_id    <= grant_nxt;
            active      <= active_nxt;
            err_timeout <= err_nxt;
`ifdef UART_ARB_TAG_EN
            hold        <= hold_nxt;
            data_pend   <= pend_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: producer queues, a busy-flag transmitter model and a
// rotating-service scoreboard that predicts every capture and every launched frame.
module tb_uart_tx_arbiter;
    localparam int NUM_REQ      = 4;
    localparam int BUSY_TIMEOUT = 4;
    localparam int DEPTH        = 16;
`ifdef UART_ARB_TAG_EN
    localparam int FRAMES_PER   = 2;
`else
    localparam int FRAMES_PER   = 1;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [8*NUM_REQ-1:0] req_data = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_busy = 1'b0;
    logic [2:0]           grant_id;
    logic                 active;
    logic                 err_timeout;

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .grant_id   (grant_id),
        .active     (active),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] pbuf [NUM_REQ][DEPTH];
    int         phead [NUM_REQ];
    int         ptail [NUM_REQ];
    int         rdy_cnt [NUM_REQ];
    logic [7:0] exp_q [$];
    logic [7:0] svc_q [$];
    logic [7:0] t2_bytes [4] = '{8'h10, 8'h21, 8'h32, 8'h43};
    int         model_last, busy_cnt, tmo_age, tmo_done, start_cnt, pushed, served;
    bit         busy_en, rand_en, chk_idle_next, expect_cap;

    task automatic check(input string tag, input int obs, input int want);
        n_chk++;
        if (obs == want) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, want);
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i]       = (phead[i] != ptail[i]);
            req_data[8*i +: 8] = pbuf[i][phead[i] % DEPTH];
        end
        expect_cap = rst_n && !active && (req_valid != '0);
    endtask

    task automatic push(input int r, input logic [7:0] b);
        pbuf[r][ptail[r] % DEPTH] = b;
        ptail[r]++;
        pushed++;
        apply_inputs();
    endtask

    task automatic model_reset();
        exp_q.delete();
        model_last    = NUM_REQ - 1;
        busy_cnt      = 0;
        tx_busy       = 1'b0;
        chk_idle_next = 0;
        tmo_age       = -1;
        expect_cap    = 0;
    endtask

    // One clock of the world, evaluated at the falling edge.
    task automatic step();
        int                 win;
        int                 idx;
        logic [NUM_REQ-1:0] exp_rdy;
        @(negedge clk);
        if (chk_idle_next) begin
            if (exp_q.size() == 0) check("active_fall", int'(active), 0);
            else                   check("data_relaunch", int'(tx_start), 1);
            chk_idle_next = 0;
        end
        if (expect_cap || req_ready != '0) begin
            win     = -1;
            exp_rdy = '0;
            if (expect_cap) begin
                for (int i = 1; i <= NUM_REQ; i++) begin
                    idx = (model_last + i) % NUM_REQ;
                    if (win < 0 && req_valid[idx]) win = idx;
                end
            end
            if (win >= 0) exp_rdy[win] = 1'b1;
            check("ready", int'(req_ready), int'(exp_rdy));
            if (win >= 0) begin
                check("grant", int'(grant_id), win);
                check("start_at_cap", int'(tx_start), 1);
                check("active_at_cap", int'(active), 1);
`ifdef UART_ARB_TAG_EN
                exp_q.push_back(8'(8'hA0 | win));
`endif
                exp_q.push_back(pbuf[win][phead[win] % DEPTH]);
                svc_q.push_back(pbuf[win][phead[win] % DEPTH]);
                model_last = win;
                rdy_cnt[win]++;
                served++;
                phead[win]++;
            end
        end
        if (tmo_age >= 0) begin
            tmo_age++;
            if (tmo_age == BUSY_TIMEOUT - 1) check("err_early", int'(err_timeout), 0);
            if (tmo_age == BUSY_TIMEOUT) begin
                check("err_timeout", int'(err_timeout), 1);
                check("tmo_active", int'(active), 0);
                exp_q.delete();
                tmo_age = -1;
                tmo_done++;
            end
        end
        if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
                tx_busy       = 1'b0;
                chk_idle_next = 1;
            end
        end
        if (tx_start) begin
            start_cnt++;
            check("frame", int'(tx_data), exp_q.size() > 0 ? int'(exp_q[0]) : 256);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (busy_en) begin
                busy_cnt = $urandom_range(2, 9);
                tx_busy  = 1'b1;
            end else begin
                tmo_age = 0;
            end
        end
        if (rand_en) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if ($urandom_range(0, 7) == 0 && ptail[i] - phead[i] < 4) begin
                    pbuf[i][ptail[i] % DEPTH] = 8'($urandom);
                    ptail[i]++;
                    pushed++;
                end
            end
        end
        apply_inputs();
    endtask

    task automatic drain(input int max_cyc);
        bit done;
        done = 0;
        for (int c = 0; c < max_cyc && !done; c++) begin
            step();
            done = !active && exp_q.size() == 0 && busy_cnt == 0 && !chk_idle_next && req_valid == '0;
        end
        check("drain", int'(done), 1);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        model_reset();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit seen;
        model_reset();
        busy_en = 1;
        rand_en = 0;
        repeat (2) @(negedge clk);
        check("rst_ready", int'(req_ready), 0);
        check("rst_start", int'(tx_start), 0);
        check("rst_data", int'(tx_data), 0);
        check("rst_grant", int'(grant_id), 0);
        check("rst_active", int'(active), 0);
        check("rst_err", int'(err_timeout), 0);
        rst_n = 1'b1;

        // Single request from requester 0.
        push(0, 8'h55);
        drain(100);
        check("t1_ready0", rdy_cnt[0], 1);
        check("t1_starts", start_cnt, FRAMES_PER);
        check("t1_byte", int'(svc_q[0]), 'h55);

        // All four valid together right after reset.
        reset_pulse();
        svc_q.delete();
        for (int i = 0; i < NUM_REQ; i++) rdy_cnt[i] = 0;
        for (int i = 0; i < 4; i++) push(i, t2_bytes[i]);
        drain(300);
        for (int i = 0; i < 4; i++) begin
            check("t2_order", int'(svc_q[i]), int'(t2_bytes[i]));
            check("t2_one_ready", rdy_cnt[i], 1);
        end

        // Requester 2 just served loses to requester 3.
        svc_q.delete();
        push(2, 8'h62);
        drain(100);
        push(2, 8'h72);
        push(3, 8'h73);
        drain(200);
        check("t3_first", int'(svc_q[1]), 'h73);
        check("t3_second", int'(svc_q[2]), 'h72);

        // Random traffic.
        svc_q.delete();
        pushed  = 0;
        served  = 0;
        rand_en = 1;
        repeat (600) step();
        rand_en = 0;
        drain(600);
        check("rand_served", served, pushed);

        // Transmitter never raises busy.
        busy_en  = 0;
        tmo_done = 0;
        push(1, 8'h5A);
        repeat (BUSY_TIMEOUT + 4) step();
        check("tmo_seen", tmo_done, 1);
        check("tmo_idle", int'(active), 0);
        busy_en = 1;
        push(2, 8'h3C);
        drain(100);
        check("post_tmo_byte", int'(svc_q[$]), 'h3C);
        check("err_sticky", int'(err_timeout), 1);

        // Reset in the middle of a frame.
        push(1, 8'h99);
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            step();
            seen = tx_busy;
        end
        check("t5_busy", int'(seen), 1);
        step();
        rst_n = 1'b0;
        #1;
        check("mid_rst_start", int'(tx_start), 0);
        check("mid_rst_active", int'(active), 0);
        check("mid_rst_ready", int'(req_ready), 0);
        check("mid_rst_grant", int'(grant_id), 0);
        check("mid_rst_err", int'(err_timeout), 0);
        model_reset();
        step();
        rst_n = 1'b1;
        svc_q.delete();
        push(0, 8'h01);
        push(3, 8'h03);
        drain(200);
        check("t5_first", int'(svc_q[0]), 'h01);
        check("t5_second", int'(svc_q[1]), 'h03);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
